tdm_mux_param: RTL

Parametrised time-division multiplexer. Scans NUM_CH input channels of DATA_W bits each and presents one channel at a time on a single registered output.
- Each channel is held for a programmable dwell period.
- Disabled channels are skipped.
- Outputs include the active channel index, a valid flag and a frame-start pulse.
- Sits between parallel sample sources and a shared serial link or display-scan stage.

---
 rtl/tdm_mux_param.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tdm_mux_param.sv
// Time-division multiplexer: scans enabled channels onto one registered
// output, holding each for a programmable dwell period.
module tdm_mux_param #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 2,
  parameter int DWELL_W = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_bus,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic                     hold,
  output logic [DATA_W-1:0]        out,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_valid,
  output logic                     frame_start
);

  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWELL_W-1:0] slot_len_q, slot_len_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic [CH_W-1:0]    out_ch_q, out_ch_d;
  logic               out_valid_q, out_valid_d;
  logic               frame_start_q, frame_start_d;

  logic [DATA_W-1:0]  ch_data [NUM_CH];
  logic [CH_W-1:0]    low_ch;
  logic [CH_W-1:0]    hi_ch;
  logic               hi_found;
  logic [CH_W-1:0]    sel;

  function automatic logic [CH_W-1:0] wrap_inc(
    input logic [CH_W-1:0] c
  );
    return (c == CH_W'(NUM_CH - 1)) ? '0 : c + 1'b1;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      ch_data[k] = in_bus[k*DATA_W +: DATA_W];
    end
  end

  // Wrapped search = first enabled at/above ptr, else lowest enabled.
  always_comb begin
    low_ch   = '0;
    hi_ch    = '0;
    hi_found = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_en[k]) begin
        low_ch = CH_W'(k);
        if (CH_W'(k) >= ptr_q) begin
          hi_ch    = CH_W'(k);
          hi_found = 1'b1;
        end
      end
    end
    sel = hi_found ? hi_ch : low_ch;
  end

  always_comb begin
    ptr_d         = ptr_q;
    dwell_cnt_d   = dwell_cnt_q;
    slot_len_d    = slot_len_q;
    out_d         = out_q;
    out_ch_d      = out_ch_q;
    out_valid_d   = out_valid_q;
    frame_start_d = frame_start_q;
    if (hold) begin
      ptr_d = ptr_q;
    end else if (ch_en == '0) begin
      ptr_d         = '0;
      dwell_cnt_d   = '0;
      out_d         = '0;
      out_ch_d      = '0;
      out_valid_d   = 1'b0;
      frame_start_d = 1'b0;
    end else if (dwell_cnt_q == '0) begin
      out_d         = ch_data[sel];
      out_ch_d      = sel;
      out_valid_d   = 1'b1;
      slot_len_d    = dwell;
      frame_start_d = (sel == low_ch);
      if (dwell == '0) begin
        ptr_d = wrap_inc(sel);
      end else begin
        dwell_cnt_d = DWELL_W'(1);
      end
    end else begin
      out_d         = ch_data[out_ch_q];
      out_valid_d   = 1'b1;
      frame_start_d = 1'b0;
      if (dwell_cnt_q == slot_len_q) begin
        dwell_cnt_d = '0;
        ptr_d       = wrap_inc(out_ch_q);
      end else begin
        dwell_cnt_d = dwell_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= '0;
      dwell_cnt_q   <= '0;
      slot_len_q    <= '0;
      out_q         <= '0;
      out_ch_q      <= '0;
      out_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      ptr_q         <= ptr_d;
      dwell_cnt_q   <= dwell_cnt_d;
      slot_len_q    <= slot_len_d;
      out_q         <= out_d;
      out_ch_q      <= out_ch_d;
      out_valid_q   <= out_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign out         = out_q;
  assign out_ch      = out_ch_q;
  assign out_valid   = out_valid_q;
  assign frame_start = frame_start_q;

endmodule
